// File: rtl/bus_arbiter_pkg.sv
// Shared types and default constants for the bus_arbiter block.
// Optional hold limit is enabled by the BUS_ARB_TIMEOUT_EN macro.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StTurn
  } state_e;

  localparam int unsigned DefN       = 2;
  localparam int unsigned DefTurn    = 1;
  localparam int unsigned DefMaxHold = 8;

  // Index width that stays legal even for degenerate sizes.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the bus users and the arbiter.
// master: arbiter side; slave: bus-user side.
interface bus_arbiter_if
  import bus_arb_pkg::*;
#(
  parameter int unsigned N = DefN
);

  logic [N-1:0]              req;
  logic [N-1:0]              gnt;
  logic [id_width(N)-1:0]    gnt_id;
  logic                      busy;
  logic                      timeout;

  modport master (
    input  req,
    output gnt,
    output gnt_id,
    output busy,
    output timeout
  );

  modport slave (
    output req,
    input  gnt,
    input  gnt_id,
    input  busy,
    input  timeout
  );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_i,
// wrapping modulo N.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int unsigned N = DefN
) (
  input  logic [N-1:0]           req_i,
  input  logic [id_width(N)-1:0] last_i,
  output logic                   valid_o,
  output logic [id_width(N)-1:0] idx_o,
  output logic [N-1:0]           onehot_o
);

  localparam int unsigned IdW = id_width(N);

  int unsigned cand;

  always_comb begin
    valid_o  = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    cand     = 0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand = (32'(last_i) + off) % N;
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand[IdW-1:0];
      end
    end
    if (valid_o) begin
      onehot_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a turnaround gap between owners.
// Define BUS_ARB_TIMEOUT_EN to bound ownership to MAX_HOLD cycles.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned N        = DefN,
  parameter int unsigned TURN     = DefTurn,
  parameter int unsigned MAX_HOLD = DefMaxHold
) (
  input  logic          clk,
  input  logic          rst_n,
  bus_arbiter_if.master bus
);

  localparam int unsigned IdW   = id_width(N);
  localparam int unsigned TurnW = $clog2(TURN + 1);

  if (N < 2) begin : gen_bad_n
    $error("bus_arbiter: N must be at least 2");
  end
  if (TURN < 1) begin : gen_bad_turn
    $error("bus_arbiter: TURN must be at least 1");
  end
  if (MAX_HOLD < 1) begin : gen_bad_max_hold
    $error("bus_arbiter: MAX_HOLD must be at least 1");
  end

  state_e           state_q, state_d;
  logic [IdW-1:0]   last_q, last_d;
  logic [TurnW-1:0] turn_q, turn_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IdW-1:0]   gnt_id_q, gnt_id_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic             rel;

  logic             pick_valid;
  logic [IdW-1:0]   pick_idx;
  logic [N-1:0]     pick_onehot;

  rr_pick #(
    .N (N)
  ) u_rr_pick (
    .req_i    (bus.req),
    .last_i   (last_q),
    .valid_o  (pick_valid),
    .idx_o    (pick_idx),
    .onehot_o (pick_onehot)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);

  logic [HoldW-1:0] hold_q, hold_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    turn_d    = turn_q;
    gnt_d     = '0;
    gnt_id_d  = '0;
    timeout_d = 1'b0;
    rel       = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
    hold_d    = hold_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StGrant;
          last_d  = pick_idx;
`ifdef BUS_ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end

      StGrant: begin
        // last_q doubles as the current owner while in StGrant.
        rel = !bus.req[last_q];
`ifdef BUS_ARB_TIMEOUT_EN
        if (!rel && hold_q == HoldW'(MAX_HOLD - 1)) begin
          rel       = 1'b1;
          timeout_d = 1'b1;
        end else if (hold_q != HoldW'(MAX_HOLD - 1)) begin
          hold_d = hold_q + 1'b1;
        end
`endif
        if (rel) begin
          state_d = StTurn;
          turn_d  = TurnW'(TURN - 1);
        end
      end

      StTurn: begin
        if (turn_q == '0) begin
          if (pick_valid) begin
            state_d = StGrant;
            last_d  = pick_idx;
`ifdef BUS_ARB_TIMEOUT_EN
            hold_d  = '0;
`endif
          end else begin
            state_d = StIdle;
          end
        end else begin
          turn_d = turn_q - 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase

    if (state_d == StGrant) begin
      gnt_d[last_d] = 1'b1;
      gnt_id_d      = last_d;
    end
    busy_d = |gnt_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      last_q    <= IdW'(N - 1);
      turn_q    <= '0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      turn_q    <= turn_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: two instances (TURN=1 and TURN=3)
// share one request vector and are compared against a per-cycle reference model.
module tb_bus_arbiter;

  localparam int unsigned N        = 2;
  localparam int unsigned MAX_HOLD = 4;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;

  int checks = 0;
  int errors = 0;

  // Model state per instance: owner (-1 = none), remaining gap, rr pointer,
  // cycles held so far, expected timeout pulse.
  int turn_len [2] = '{1, 3};
  int owner    [2];
  int gap      [2];
  int last     [2];
  int held     [2];
  bit to_exp   [2];

  bus_arbiter_if #(.N(N)) bus_a ();
  bus_arbiter_if #(.N(N)) bus_b ();

  assign bus_a.req = req;
  assign bus_b.req = req;

  bus_arbiter #(
    .N        (N),
    .TURN     (1),
    .MAX_HOLD (MAX_HOLD)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  bus_arbiter #(
    .N        (N),
    .TURN     (3),
    .MAX_HOLD (MAX_HOLD)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      owner[k]  = -1;
      gap[k]    = 0;
      last[k]   = N - 1;
      held[k]   = 0;
      to_exp[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input logic [N-1:0] r);
    int w;
    to_exp[k] = 1'b0;
    if (owner[k] >= 0) begin
      if (!r[owner[k]]) begin
        owner[k] = -1;
        gap[k]   = turn_len[k];
      end else if (TO_EN && held[k] == MAX_HOLD) begin
        owner[k]  = -1;
        gap[k]    = turn_len[k];
        to_exp[k] = 1'b1;
      end else begin
        held[k]++;
      end
    end else begin
      if (gap[k] > 0) gap[k]--;
      if (gap[k] == 0 && r != '0) begin
        w = -1;
        for (int i = 1; i <= N; i++) begin
          if (w < 0 && r[(last[k] + i) % N]) w = (last[k] + i) % N;
        end
        owner[k] = w;
        last[k]  = w;
        held[k]  = 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input string name, input int k, input logic [N-1:0] g,
                            input logic gid, input logic b, input logic t);
    logic [N-1:0] g_exp;
    g_exp = '0;
    if (owner[k] >= 0) g_exp[owner[k]] = 1'b1;
    check({name, ".gnt"}, 32'(g), 32'(g_exp));
    check({name, ".gnt_id"}, 32'(gid), (owner[k] >= 0) ? owner[k] : 0);
    check({name, ".busy"}, 32'(b), 32'(owner[k] >= 0));
    check({name, ".busy_or"}, 32'(b), 32'(|g));
    check({name, ".timeout"}, 32'(t), 32'(to_exp[k]));
  endtask

  task automatic check_all();
    check_inst("a", 0, bus_a.gnt, bus_a.gnt_id, bus_a.busy, bus_a.timeout);
    check_inst("b", 1, bus_b.gnt, bus_b.gnt_id, bus_b.busy, bus_b.timeout);
  endtask

  // One clock: model advances on the rising edge, outputs compared on the falling edge.
  task automatic cycle();
    logic [N-1:0] r;
    @(posedge clk);
    r = req;
    if (!rst_n) model_reset();
    else begin
      model_step(0, r);
      model_step(1, r);
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input logic [N-1:0] r, input int n);
    req = r;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    model_reset();
    run(2'b00, 3);
    rst_n = 1'b1;
    run(2'b00, 2);

    // Single request from user 0, then release.
    run(2'b01, 5);
    run(2'b00, 5);

    // Single request from user 1.
    run(2'b10, 3);
    run(2'b00, 5);

    // Contention with owners releasing in turn.
    for (int j = 0; j < 4; j++) begin
      run(2'b11, 3);
      run((bus_a.gnt_id == 1'b0) ? 2'b10 : 2'b01, 1);
      run(2'b11, 5);
    end
    run(2'b00, 5);

    // Continuous request from user 0: hold limit only when enabled.
    run(2'b01, 100);
    run(2'b11, 20);
    run(2'b00, 5);

    // Asynchronous reset in the middle of a grant.
    run(2'b11, 3);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    run(2'b11, 2);
    rst_n = 1'b1;
    run(2'b11, 1);
    check("reset_first_owner", 32'(bus_a.gnt), 32'h1);
    run(2'b00, 5);

    // Random request traffic with sticky bits.
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] flip;
      for (int b = 0; b < N; b++) flip[b] = ($urandom_range(0, 4) == 0);
      run(req ^ flip, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
